// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO slave.
// Register word addresses and edge-capture encodings.
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_DIR     = 3'd1;
  localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus per-bit edge detector.
// Flops reset to 0, so a pad held high through reset yields a rising edge.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic [DATA_WIDTH-1:0] sync_o,
  output logic [DATA_WIDTH-1:0] edge_o
);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise   = sync_o & ~prev_q;
  assign fall   = ~sync_o & prev_q;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_o = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_o = rise | fall;
    end else begin : g_rise
      assign edge_o = rise;
    end
  endgenerate

endmodule

// File: rtl/avmm_pio_ctrl.sv
// Avalon-MM GPIO slave: data, direction, irq mask, edge capture.
// Define PIO_BITSET_EN to add atomic OUTSET/OUTCLR registers.
module avmm_pio_ctrl
  import pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  irq_q, irq_d;
  logic [31:0]           rdata;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .in_i   (in_port),
    .sync_o (sync_in),
    .edge_o (edge_det)
  );

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      unique case (address)
        PIO_ADDR_DATA:    out_d  = wd;
        PIO_ADDR_DIR:     dir_d  = wd;
        PIO_ADDR_IRQMASK: mask_d = wd;
        PIO_ADDR_EDGECAP: clr    = wd;
`ifdef PIO_BITSET_EN
        PIO_ADDR_OUTSET:  out_d  = out_q | wd;
        PIO_ADDR_OUTCLR:  out_d  = out_q & ~wd;
`endif
        default: ;
      endcase
    end
    // new edges override a same-cycle clear
    cap_d = (cap_q & ~clr) | edge_det;
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_OUT[DATA_WIDTH-1:0];
      dir_q  <= RESET_DIR[DATA_WIDTH-1:0];
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      PIO_ADDR_DATA:    rdata[DATA_WIDTH-1:0] = sync_in;
      PIO_ADDR_DIR:     rdata[DATA_WIDTH-1:0] = dir_q;
      PIO_ADDR_IRQMASK: rdata[DATA_WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGECAP: rdata[DATA_WIDTH-1:0] = cap_q;
`ifdef PIO_BITSET_EN
      PIO_ADDR_OUTSET,
      PIO_ADDR_OUTCLR:  rdata[DATA_WIDTH-1:0] = out_q;
`endif
      default: ;
    endcase
  end

  assign readdata = rdata;
  assign out_port = out_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;

endmodule
